// File: rtl/counter_arb_pkg.sv
// Shared definitions for the arbitrated counter: command opcodes and
// sequencer state encoding.
package counter_arb_pkg;

    // Command opcodes carried on req_op, two bits per requester
    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    // Sequencer states: accept a command, apply it, present the response
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/counter_access_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches the request vector upward starting one
// position past the previous winner and wraps modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int   cand;
    logic found;

    // Priority search; the previous winner is examined last
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/counter_access_arbiter.sv
// Single shared counter register accessed by NUM_REQ requesters through a
// round-robin arbiter and a three-state IDLE/EXEC/RESP sequencer.
//
// Handshake: a command transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; a response transfers on a rising edge where
// resp_valid and resp_ready are both high. req_ready depends only on state,
// reset and req_valid, never on resp_ready.
module counter_access_arbiter
    import counter_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [IDX_W-1:0]         resp_id,
    output logic [WIDTH-1:0]         resp_data,
    output logic [WIDTH-1:0]         count_out
);

    state_t            state;
    logic [IDX_W-1:0]  last_grant;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic [1:0]        lat_op;
    logic [WIDTH-1:0]  lat_data;
    logic [IDX_W-1:0]  lat_id;
    logic [WIDTH-1:0]  next_count;
    logic              accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Grant is only offered while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && !reset) begin
            req_ready = grant;
        end
        accept = |(req_valid & req_ready);
    end

    // Counter value produced by the latched command; wraps at WIDTH bits
    always_comb begin
        next_count = count_out;
        case (lat_op)
            OP_INC:  next_count = count_out + WIDTH'(1);
            OP_DEC:  next_count = count_out - WIDTH'(1);
            OP_LOAD: next_count = lat_data;
            default: next_count = count_out;
        endcase
    end

    // Sequencer, counter register and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            count_out  <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            lat_op     <= OP_READ;
            lat_data   <= '0;
            lat_id     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_op     <= req_op[2*int'(grant_idx) +: 2];
                        lat_data   <= req_data[WIDTH*int'(grant_idx) +: WIDTH];
                        lat_id     <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    count_out  <= next_count;
                    resp_data  <= next_count;
                    resp_id    <= lat_id;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Directed bench for counter_access_arbiter: reset values, handshake timing,
// round-robin order, wrap-around arithmetic, response stall, reset during a
// command and a non-granted valid pulse.
module tb_counter_access_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [1:0]               resp_id;
    logic [WIDTH-1:0]         resp_data;
    logic [WIDTH-1:0]         count_out;

    int n_checks;
    int n_pass;

    counter_access_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .count_out  (count_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [31:0] data);
        req_valid[id]            = 1'b1;
        req_op[2*id +: 2]        = op;
        req_data[WIDTH*id +: WIDTH] = data;
    endtask

    // Single requester command, response accepted immediately
    task automatic do_cmd(input string tag, input int id, input logic [1:0] op,
                          input logic [31:0] data, input logic [31:0] exp);
        resp_ready = 1'b1;
        req_valid  = '0;
        set_req(id, op, data);
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
        step();
        req_valid = '0;
        step();
        check({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
        check({tag, "_rid"}, 32'(resp_id), 32'(id));
        check({tag, "_rdata"}, resp_data, exp);
        check({tag, "_count"}, count_out, exp);
        step();
        check({tag, "_rdone"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        req_valid  = '0;
        req_op     = '0;
        req_data   = '0;
        resp_ready = 1'b0;

        // Reset values; req_ready held low even with every requester valid
        step();
        step();
        req_valid = '1;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_count", count_out, 32'd0);
        check("rst_rvalid", 32'(resp_valid), 32'd0);
        check("rst_rid", 32'(resp_id), 32'd0);
        check("rst_rdata", resp_data, 32'd0);
        req_valid = '0;
        reset     = 1'b0;
        step();

        // LOAD 0xFF from requester 0, checking each cycle of the sequence
        set_req(0, 2'b11, 32'h0000_00FF);
        #1;
        check("load_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        #1;
        check("load_exec_ready", 32'(req_ready), 32'd0);
        check("load_exec_count", count_out, 32'd0);
        check("load_exec_rvalid", 32'(resp_valid), 32'd0);
        step();
        check("load_count", count_out, 32'h0000_00FF);
        check("load_rvalid", 32'(resp_valid), 32'd1);
        check("load_rid", 32'(resp_id), 32'd0);
        check("load_rdata", resp_data, 32'h0000_00FF);
        resp_ready = 1'b1;
        step();
        check("load_rdone", 32'(resp_valid), 32'd0);

        // Four requesters hold INC: grants 0,1,2,3,0 at one per 3 cycles
        do_reset();
        resp_ready = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) set_req(r, 2'b01, 32'h0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            step();
            check("rr_exec_ready", 32'(req_ready), 32'd0);
            step();
            check("rr_count", count_out, 32'(k + 1));
            check("rr_rvalid", 32'(resp_valid), 32'd1);
            check("rr_rid", 32'(resp_id), 32'(k % 4));
            check("rr_rdata", resp_data, 32'(k + 1));
            step();
        end
        req_valid = '0;
        step();

        // Wrap in both directions
        do_cmd("wrap_load", 1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_cmd("wrap_inc", 1, 2'b01, 32'h0, 32'h0000_0000);
        do_cmd("wrap_dec", 1, 2'b10, 32'h0, 32'hFFFF_FFFF);
        do_cmd("read", 2, 2'b00, 32'h5555_5555, 32'hFFFF_FFFF);

        // Response stall with other requesters waiting (last grant now 2)
        resp_ready = 1'b0;
        set_req(3, 2'b11, 32'h0000_00AB);
        step();
        req_valid = '0;
        step();
        for (int r = 0; r < 3; r++) set_req(r, 2'b01, 32'h0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_rvalid", 32'(resp_valid), 32'd1);
            check("stall_rid", 32'(resp_id), 32'd3);
            check("stall_rdata", resp_data, 32'h0000_00AB);
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_count", count_out, 32'h0000_00AB);
            step();
        end
        resp_ready = 1'b1;
        step();
        check("stall_done", 32'(resp_valid), 32'd0);
        // Requester 0 is next after 3; it drops valid before the edge
        check("stall_next_ready", 32'(req_ready), 32'h1);
        req_valid = '0;
        #1;
        check("drop_ready", 32'(req_ready), 32'd0);
        step();
        step();
        check("drop_no_resp", 32'(resp_valid), 32'd0);
        check("drop_count", count_out, 32'h0000_00AB);

        // Reset while a LOAD 0x1234 is in EXEC
        set_req(2, 2'b11, 32'h0000_1234);
        step();
        req_valid = '0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        check("rexec_count", count_out, 32'd0);
        check("rexec_rvalid", 32'(resp_valid), 32'd0);
        check("rexec_rdata", resp_data, 32'd0);
        step();
        check("rexec_rvalid2", 32'(resp_valid), 32'd0);
        check("rexec_count2", count_out, 32'd0);
        req_valid = '1;
        #1;
        check("rexec_next_grant", 32'(req_ready), 32'h1);
        req_valid = '0;
        step();

        // Requester 2 valid for one cycle while requester 0 wins
        set_req(0, 2'b01, 32'h0);
        set_req(2, 2'b11, 32'h0000_7777);
        #1;
        check("pulse_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        step();
        check("pulse_rid", 32'(resp_id), 32'd0);
        check("pulse_rdata", resp_data, 32'd1);
        step();
        step();
        step();
        check("pulse_no_resp", 32'(resp_valid), 32'd0);
        check("pulse_count", count_out, 32'd1);
        // Pointer sits at 0, so requester 1 is preferred over 2 and 0
        req_valid = '1;
        #1;
        check("pulse_ptr", 32'(req_ready), 32'h2);
        req_valid = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
